// File: rtl/reg_wb_arbiter_pkg.sv
// Shared types for the register writeback path: widths, queued request, arbiter state.
// No logic; types only.
// No backpressure; types only.
package reg_wb_arbiter_pkg;

  localparam int RV_ADW = 5;
  localparam int RV_DPW = 32;

  typedef struct packed {
    logic [RV_ADW-1:0] rd;
    logic [RV_DPW-1:0] data;
  } wb_req_t;

  typedef enum logic {
    WB_NORMAL = 1'b0,
    WB_DRAIN  = 1'b1
  } wb_state_e;

endpackage

// File: rtl/reg_wb_arbiter_fifo.sv
// Synchronous FIFO of writeback requests, with a per-slot valid view for hazard masks.
// Latency: a push is visible at head on the next cycle; there is no same-cycle pass-through.
// Backpressure: push is ignored when full, pop is ignored when empty.
module reg_wb_arbiter_fifo
  import reg_wb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  wb_req_t                push_dat_i,
  input  logic                   pop_i,
  output wb_req_t                head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic [DEPTH-1:0]       ent_vld_o,
  output wb_req_t                ent_o [DEPTH]
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t         mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            push_ok;
  logic            pop_ok;
  logic [PW-1:0]   off;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Storage array: data only, validity is tracked by pointers and count.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_dat_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    off       = '0;
    ent_vld_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = PW'(i) - rd_ptr_q;
      ent_vld_o[i] = (CW'(off) < cnt_q);
      ent_o[i]     = mem_q[i];
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// Merges ALU and LSU writebacks onto the reg_file write port; LSU results wait in a queue.
// Latency: ALU 1 cycle to the write port, LSU at least 2 cycles (always through the queue).
// Backpressure: lsu_ready drops when the queue is full; alu_ready drops while draining.
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int ADW      = RV_ADW,
  parameter int DPW      = RV_DPW,
  parameter int LQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADW-1:0]    alu_rd,
  input  logic [DPW-1:0]    alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADW-1:0]    lsu_rd,
  input  logic [DPW-1:0]    lsu_data,
  output logic [ADW-1:0]    addr_3,
  output logic              we_3,
  output logic [DPW-1:0]    wd_3,
  output logic [2**ADW-1:0] pend_mask
);

  localparam int CW = $clog2(LQ_DEPTH) + 1;

  wb_state_e       state_q, state_d;
  logic            we_q, we_d;
  logic [ADW-1:0]  addr_q, addr_d;
  logic [DPW-1:0]  wd_q, wd_d;

  logic            alu_acc;
  logic            lsu_acc;
  logic            lq_push;
  logic            lq_pop;
  wb_req_t         lq_push_dat;
  wb_req_t         lq_head;
  logic            lq_full;
  logic            lq_empty;
  logic [CW-1:0]   lq_count;
  logic [CW-1:0]   cnt_next;
  logic [LQ_DEPTH-1:0] lq_ent_vld;
  wb_req_t         lq_ent [LQ_DEPTH];

  assign alu_ready   = (state_q == WB_NORMAL);
  assign lsu_ready   = !lq_full;
  assign alu_acc     = alu_valid && alu_ready;
  assign lsu_acc     = lsu_valid && lsu_ready;
  // Loads to x0 are accepted but never occupy a queue slot.
  assign lq_push     = lsu_acc && (lsu_rd != '0);
  // An accepted ALU request owns the port; in DRAIN no ALU request is accepted.
  assign lq_pop      = !lq_empty && !alu_acc;
  assign lq_push_dat = '{rd: lsu_rd, data: lsu_data};
  assign cnt_next    = lq_count + CW'(lq_push) - CW'(lq_pop);

  reg_wb_arbiter_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (lq_push),
    .push_dat_i (lq_push_dat),
    .pop_i      (lq_pop),
    .head_o     (lq_head),
    .full_o     (lq_full),
    .empty_o    (lq_empty),
    .count_o    (lq_count),
    .ent_vld_o  (lq_ent_vld),
    .ent_o      (lq_ent)
  );

  // Enter DRAIN when the queue fills; leave once it is back to half or less.
  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_NORMAL: if (cnt_next == CW'(LQ_DEPTH))     state_d = WB_DRAIN;
      WB_DRAIN:  if (cnt_next <= CW'(LQ_DEPTH / 2)) state_d = WB_NORMAL;
      default:                                      state_d = WB_NORMAL;
    endcase
  end

  // Pick this cycle's write-port winner; an idle port keeps its last address/data.
  always_comb begin
    we_d   = 1'b0;
    addr_d = addr_q;
    wd_d   = wd_q;
    if (alu_acc) begin
      if (alu_rd != '0) begin
        we_d   = 1'b1;
        addr_d = alu_rd;
        wd_d   = alu_data;
      end
    end else if (lq_pop) begin
      we_d   = 1'b1;
      addr_d = lq_head.rd;
      wd_d   = lq_head.data;
    end
  end

  // State and write-port registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= WB_NORMAL;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
    end
  end

  assign we_3   = we_q;
  assign addr_3 = addr_q;
  assign wd_3   = wd_q;

  // Destinations still owed a write: every live queue slot plus the write in flight.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < LQ_DEPTH; i++) begin
      if (lq_ent_vld[i]) pend_mask[lq_ent[i].rd] = 1'b1;
    end
    if (we_q) pend_mask[addr_q] = 1'b1;
    pend_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_reg_wb_arbiter.sv
module tb_reg_wb_arbiter;

  localparam int LQ = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, lsu_valid;
  logic        alu_ready, lsu_ready;
  logic [4:0]  alu_rd, lsu_rd, addr_3;
  logic [31:0] alu_data, lsu_data, wd_3;
  logic        we_3;
  logic [31:0] pend_mask;

  reg_wb_arbiter #(.ADW(5), .DPW(32), .LQ_DEPTH(LQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .addr_3(addr_3), .we_3(we_3), .wd_3(wd_3), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  typedef struct { logic [4:0] rd; logic [31:0] d; } req_t;

  typedef struct {
    logic av; logic [4:0] ard; logic [31:0] ad;
    logic lv; logic [4:0] lrd; logic [31:0] ld;
    logic we; logic [4:0] addr; logic [31:0] wd; logic [31:0] pend;
    logic ardy; logic lrdy;
  } vec_t;

  int checks = 0;
  int errors = 0;

  // reference model state
  req_t        lq[$];
  bit          m_drain = 0;
  bit          last_a_acc = 0;
  bit          last_l_acc = 0;
  logic [31:0] rf_ref [32];
  logic [31:0] rf_dut [32];
  vec_t        tbl [18];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] oh(input logic [4:0] r);
    logic [31:0] v;
    v = 32'd1 << r;
    return v;
  endfunction

  function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                              input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                              input logic we, input logic [4:0] addr, input logic [31:0] wd,
                              input logic [31:0] pend, input logic ardy, input logic lrdy);
    vec_t v;
    v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.we = we; v.addr = addr; v.wd = wd; v.pend = pend; v.ardy = ardy; v.lrdy = lrdy;
    return v;
  endfunction

  // One clock: inputs already driven; model predicts what the edge does and checks the DUT.
  task automatic step();
    bit          a_acc, l_acc, exp_we;
    logic [4:0]  a_rd, l_rd, exp_addr;
    logic [31:0] a_d, l_d, exp_wd, exp_pend;
    req_t        e;
    a_acc = alu_valid && !m_drain;
    l_acc = lsu_valid && (lq.size() < LQ);
    a_rd = alu_rd; a_d = alu_data; l_rd = lsu_rd; l_d = lsu_data;
    @(posedge clk); #1;
    exp_we = 0; exp_addr = 0; exp_wd = 0;
    if (a_acc) begin
      if (a_rd != 0) begin
        exp_we = 1; exp_addr = a_rd; exp_wd = a_d; rf_ref[a_rd] = a_d;
      end
    end else if (lq.size() > 0) begin
      e = lq.pop_front();
      exp_we = 1; exp_addr = e.rd; exp_wd = e.d;
    end
    if (l_acc && l_rd != 0) begin
      e.rd = l_rd; e.d = l_d;
      lq.push_back(e);
      rf_ref[l_rd] = l_d;
    end
    if (!m_drain && lq.size() == LQ) m_drain = 1;
    else if (m_drain && lq.size() <= LQ / 2) m_drain = 0;
    exp_pend = 0;
    foreach (lq[k]) exp_pend |= oh(lq[k].rd);
    if (exp_we) exp_pend |= oh(exp_addr);
    exp_pend[0] = 1'b0;
    chk("model_we", we_3, exp_we);
    if (exp_we) begin
      chk("model_addr", addr_3, exp_addr);
      chk("model_wd", wd_3, exp_wd);
    end
    chk("model_pend", pend_mask, exp_pend);
    chk("model_alu_ready", alu_ready, !m_drain);
    chk("model_lsu_ready", lsu_ready, lq.size() < LQ);
    if (we_3) rf_dut[addr_3] = wd_3;
    last_a_acc = a_acc;
    last_l_acc = l_acc;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
  endtask

  task automatic do_reset(input string nm);
    rst_n = 0;
    idle_inputs();
    @(posedge clk); #1;
    chk({nm, "_we"}, we_3, 0);
    chk({nm, "_pend"}, pend_mask, 0);
    chk({nm, "_lsu_ready"}, lsu_ready, 1);
    chk({nm, "_alu_ready"}, alu_ready, 1);
    rst_n = 1;
    lq.delete();
    m_drain = 0;
    last_a_acc = 0;
    last_l_acc = 0;
  endtask

  initial begin
    // ALU only, then ALU to x0
    tbl[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,      1, 5, 32'hDEADBEEF, 32'h20, 1, 1);
    tbl[1]  = mk(1, 0, 32'h11111111, 0, 0, 0,      0, 0, 0,            32'h0,  1, 1);
    // LSU alone
    tbl[2]  = mk(0, 0, 0, 1, 7, 32'h1234,          0, 0, 0,            32'h80, 1, 1);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0,                 1, 7, 32'h1234,     32'h80, 1, 1);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0,                 0, 0, 0,            32'h0,  1, 1);
    // ALU and LSU to the same register
    tbl[5]  = mk(1, 3, 32'hAAAA, 1, 3, 32'hBBBB,   1, 3, 32'hAAAA,     32'h8,  1, 1);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0,                 1, 3, 32'hBBBB,     32'h8,  1, 1);
    tbl[7]  = mk(0, 0, 0, 0, 0, 0,                 0, 0, 0,            32'h0,  1, 1);
    // continuous ALU while four loads fill the queue
    tbl[8]  = mk(1, 1, 32'hA0, 1, 10, 32'hC0,      1, 1, 32'hA0,       32'h402,  1, 1);
    tbl[9]  = mk(1, 1, 32'hA1, 1, 11, 32'hC1,      1, 1, 32'hA1,       32'hC02,  1, 1);
    tbl[10] = mk(1, 1, 32'hA2, 1, 12, 32'hC2,      1, 1, 32'hA2,       32'h1C02, 1, 1);
    tbl[11] = mk(1, 1, 32'hA3, 1, 13, 32'hC3,      1, 1, 32'hA3,       32'h3C02, 0, 0);
    tbl[12] = mk(1, 1, 32'hA4, 0, 0, 0,            1, 10, 32'hC0,      32'h3C00, 0, 1);
    tbl[13] = mk(1, 1, 32'hA4, 0, 0, 0,            1, 11, 32'hC1,      32'h3800, 1, 1);
    tbl[14] = mk(1, 1, 32'hA4, 0, 0, 0,            1, 1, 32'hA4,       32'h3002, 1, 1);
    tbl[15] = mk(0, 0, 0, 0, 0, 0,                 1, 12, 32'hC2,      32'h3000, 1, 1);
    tbl[16] = mk(0, 0, 0, 0, 0, 0,                 1, 13, 32'hC3,      32'h2000, 1, 1);
    tbl[17] = mk(0, 0, 0, 0, 0, 0,                 0, 0, 0,            32'h0,    1, 1);

    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_we", we_3, 0);
    chk("rst_addr", addr_3, 0);
    chk("rst_wd", wd_3, 0);
    chk("rst_pend", pend_mask, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_lsu_ready", lsu_ready, 1);
    rst_n = 1;

    for (int i = 0; i < 18; i++) begin
      alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_data = tbl[i].ad;
      lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_data = tbl[i].ld;
      step();
      chk($sformatf("vec%0d_we", i), we_3, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("vec%0d_addr", i), addr_3, tbl[i].addr);
        chk($sformatf("vec%0d_wd", i), wd_3, tbl[i].wd);
      end
      chk($sformatf("vec%0d_pend", i), pend_mask, tbl[i].pend);
      chk($sformatf("vec%0d_alu_ready", i), alu_ready, tbl[i].ardy);
      chk($sformatf("vec%0d_lsu_ready", i), lsu_ready, tbl[i].lrdy);
    end

    // reset with three loads queued behind a busy ALU
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1; alu_rd = 2; alu_data = 32'h500 + i;
      lsu_valid = 1; lsu_rd = 5'(20 + i); lsu_data = 32'h600 + i;
      step();
    end
    chk("pre_rst_pend", pend_mask, oh(20) | oh(21) | oh(22) | oh(2));
    do_reset("midrst");
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("post_rst%0d_we", i), we_3, 0);
    end

    // randomized traffic; ALU and LSU use disjoint destinations so final contents are unique
    for (int r = 0; r < 32; r++) begin
      rf_ref[r] = 0;
      rf_dut[r] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      if (!(alu_valid && !last_a_acc)) begin
        alu_valid = ($urandom_range(0, 99) < ((c < 1500) ? 50 : 85));
        alu_rd    = 5'($urandom_range(0, 15));
        alu_data  = $urandom;
      end
      if (!(lsu_valid && !last_l_acc)) begin
        lsu_valid = ($urandom_range(0, 99) < 70);
        lsu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
        lsu_data  = $urandom;
      end
      step();
    end
    idle_inputs();
    repeat (8) step();
    chk("drained_pend", pend_mask, 0);
    for (int r = 1; r < 32; r++) begin
      chk($sformatf("rf_x%0d", r), rf_dut[r], rf_ref[r]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
